// File: rtl/conv1_filter_q16.sv
// conv1_filter_q16: one 3x3 conv filter, signed Q16.16.
// Three register stages: per-lane products, full-precision adder tree, and
// floor shift plus ReLU plus saturation.
// rst_n is active-high, despite its name.
`timescale 1ns/1ps

// Per-lane multiplier. Holds one full-precision Q32.32 product.
module conv1_filter_q16_lane #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   p
);
  localparam int PW = 2*DATA_W;

  logic [PW-1:0] a_x, b_x;
  // Sign-extend both operands first, so the low PW bits of the product are exact.
  assign a_x = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_x = {{DATA_W{b[DATA_W-1]}}, b};

  // Capture the product only on a valid window. Otherwise the register holds.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)   p <= '0;
    else if (en) p <= a_x * b_x;
  end
endmodule

module conv1_filter_q16 #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_out [0:8],
  input  logic [DATA_W-1:0] weight   [0:8],
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] filter_out
);
  localparam int NUM_LANES = 9;
  localparam int STAGES    = 2;           // valid stages that follow the input
  localparam int PROD_W    = 2*DATA_W;
  localparam int SUM_W     = PROD_W + 4;  // 10 addends need 4 guard bits
  localparam int EXT_W     = SUM_W - PROD_W;

  logic [NUM_LANES-1:0][PROD_W-1:0] prod_q;
  logic [PROD_W-1:0]                bias_q;
  logic [STAGES-1:0]                vld_pipe;
  logic [SUM_W-1:0]                 sum_c, sum_q;
  logic signed [SUM_W-1:0]          sum_sh;
  logic [DATA_W-1:0]                res_c;

  // Stage 1: one multiplier per window element.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    conv1_filter_q16_lane #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (valid_in),
      .a     (data_out[g]),
      .b     (weight[g]),
      .p     (prod_q[g])
    );
  end

  // Stage 1: move the bias into the Q32.32 product domain.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)         bias_q <= '0;
    else if (valid_in) bias_q <= {{(PROD_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
  end

  // Valid shift register. vld_pipe[0] is v1 and vld_pipe[1] is v2.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-2:0], valid_in};
  end

  // Stage 2 adder tree. It is sign-extended and never truncated.
  always_comb begin
    sum_c = {{EXT_W{bias_q[PROD_W-1]}}, bias_q};
    for (int k = 0; k < NUM_LANES; k++)
      sum_c = sum_c + {{EXT_W{prod_q[k][PROD_W-1]}}, prod_q[k]};
  end

  // Stage 2 register. The sum updates only behind a valid stage 1.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)            sum_q <= '0;
    else if (vld_pipe[0]) sum_q <= sum_c;
  end

  // Floor back to Q16.16. Negative results clamp to 0 and large ones to the max positive.
  assign sum_sh = $signed(sum_q) >>> FRAC_W;
  always_comb begin
    res_c = sum_sh[DATA_W-1:0];
    if (sum_sh[SUM_W-1])                  res_c = '0;
    else if (|sum_sh[SUM_W-2:DATA_W-1])   res_c = {1'b0, {(DATA_W-1){1'b1}}};
  end

  // Stage 3: output register. It holds its value across bubbles.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)            filter_out <= '0;
    else if (vld_pipe[1]) filter_out <= res_c;
  end
endmodule

// File: tb/tb_conv1_filter_q16.sv
// Directed self-checking bench for conv1_filter_q16.
`timescale 1ns/1ps

module tb_conv1_filter_q16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_out [0:8];
  logic [31:0] weight   [0:8];
  logic [31:0] bias;
  logic [31:0] filter_out;
  int checks = 0;
  int failures = 0;

  conv1_filter_q16 #(.DATA_W(32), .FRAC_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .weight     (weight),
    .bias       (bias),
    .filter_out (filter_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout filter_out=%h", filter_out);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_uni(input logic [31:0] d, input logic [31:0] w, input logic [31:0] b);
    for (int k = 0; k < 9; k++) begin data_out[k] = d; weight[k] = w; end
    bias = b;
  endtask

  task automatic scramble();
    for (int k = 0; k < 9; k++) begin data_out[k] = $urandom; weight[k] = $urandom; end
    bias = $urandom;
  endtask

  // The valid edge is N. On return, the time is just after edge N+2.
  task automatic issue_and_wait();
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    scramble();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    valid_in = 1'b1;
    scramble();
    tick();
    scramble();
    tick();
    checks++;
    if (filter_out !== 32'h0) begin
      failures++; $display("FAIL reset_hold got=%h exp=%h", filter_out, 32'h0);
    end
    valid_in = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (filter_out !== 32'h0) begin
        failures++; $display("FAIL reset_idle%0d got=%h exp=%h", i, filter_out, 32'h0);
      end
    end
  endtask

  task automatic test_basic();
    set_uni(32'h0001_0000, 32'h0001_0000, 32'h0);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    checks++;
    if (filter_out !== 32'h0) begin
      failures++; $display("FAIL basic_latency_n1 got=%h exp=%h", filter_out, 32'h0);
    end
    tick();
    checks++;
    if (filter_out !== 32'h0009_0000) begin
      failures++; $display("FAIL basic_n2 got=%h exp=%h", filter_out, 32'h0009_0000);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (filter_out !== 32'h0009_0000) begin
        failures++; $display("FAIL basic_hold%0d got=%h exp=%h", i, filter_out, 32'h0009_0000);
      end
    end
  endtask

  task automatic test_bias_relu();
    set_uni(32'h0001_0000, 32'h0, 32'h0002_8000);
    issue_and_wait();
    checks++;
    if (filter_out !== 32'h0002_8000) begin
      failures++; $display("FAIL bias_only got=%h exp=%h", filter_out, 32'h0002_8000);
    end
    set_uni(32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000);
    issue_and_wait();
    checks++;
    if (filter_out !== 32'h0) begin
      failures++; $display("FAIL relu_neg8 got=%h exp=%h", filter_out, 32'h0);
    end
  endtask

  task automatic test_precision();
    set_uni(32'h0000_0001, 32'h0000_8000, 32'h0);
    issue_and_wait();
    checks++;
    if (filter_out !== 32'h0000_0004) begin
      failures++; $display("FAIL floor_pos got=%h exp=%h", filter_out, 32'h0000_0004);
    end
    set_uni(32'h0000_0001, 32'hFFFF_8000, 32'h0);
    issue_and_wait();
    checks++;
    if (filter_out !== 32'h0) begin
      failures++; $display("FAIL floor_neg got=%h exp=%h", filter_out, 32'h0);
    end
    // Each lane is distinct, so a swapped or dropped lane changes the sum.
    // The sum of squares of 1..9 is 285, and 285 - 0.5 = 284.5.
    for (int k = 0; k < 9; k++) begin
      data_out[k] = (k + 1) << 16;
      weight[k]   = (k + 1) << 16;
    end
    bias = 32'hFFFF_8000;
    issue_and_wait();
    checks++;
    if (filter_out !== 32'h011C_8000) begin
      failures++; $display("FAIL lanes_sq got=%h exp=%h", filter_out, 32'h011C_8000);
    end
  endtask

  task automatic test_saturation();
    set_uni(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    issue_and_wait();
    checks++;
    if (filter_out !== 32'h7FFF_FFFF) begin
      failures++; $display("FAIL sat_pos got=%h exp=%h", filter_out, 32'h7FFF_FFFF);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [0:2];
    exp_q[0] = 32'h0009_0000; exp_q[1] = 32'h0; exp_q[2] = 32'h0002_8000;
    valid_in = 1'b1;
    set_uni(32'h0001_0000, 32'h0001_0000, 32'h0);          tick();  // edge N, window A
    set_uni(32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000);  tick();  // edge N+1, window B
    set_uni(32'h0001_0000, 32'h0, 32'h0002_8000);          tick();  // edge N+2, window C
    valid_in = 1'b0;
    scramble();
    checks++;
    if (filter_out !== exp_q[0]) begin
      failures++; $display("FAIL b2b_0 got=%h exp=%h", filter_out, exp_q[0]);
    end
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++;
      if (filter_out !== exp_q[i]) begin
        failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, filter_out, exp_q[i]);
      end
    end
    // Hold valid high with unchanged inputs. The output stays at 9.0.
    set_uni(32'h0001_0000, 32'h0001_0000, 32'h0);
    valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 2) begin
        checks++;
        if (filter_out !== 32'h0009_0000) begin
          failures++; $display("FAIL steady%0d got=%h exp=%h", i, filter_out, 32'h0009_0000);
        end
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_uni(32'h0001_0000, 32'h0, 32'h0002_8000);
    issue_and_wait();
    set_uni(32'h0001_0000, 32'h0001_0000, 32'h0);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (filter_out !== 32'h0) begin
      failures++; $display("FAIL rst_mid_async got=%h exp=%h", filter_out, 32'h0);
    end
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (filter_out !== 32'h0) begin
        failures++; $display("FAIL rst_mid_stale%0d got=%h exp=%h", i, filter_out, 32'h0);
      end
    end
  endtask

  task automatic test_cadence();
    logic [31:0] exp_c [0:2];
    exp_c[0] = 32'h0009_0000; exp_c[1] = 32'h0002_8000; exp_c[2] = 32'h0000_0004;
    for (int w = 0; w < 3; w++) begin
      case (w)
        0: set_uni(32'h0001_0000, 32'h0001_0000, 32'h0);
        1: set_uni(32'h0001_0000, 32'h0, 32'h0002_8000);
        default: set_uni(32'h0000_0001, 32'h0000_8000, 32'h0);
      endcase
      issue_and_wait();
      // Check from just after N+2 up to just before N+9.
      for (int c = 2; c <= 8; c++) begin
        checks++;
        if (filter_out !== exp_c[w]) begin
          failures++; $display("FAIL cadence_w%0d_c%0d got=%h exp=%h", w, c, filter_out, exp_c[w]);
        end
        if (c < 8) begin scramble(); tick(); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    valid_in = 1'b0;
    set_uni(32'h0, 32'h0, 32'h0);
    test_reset();
    test_basic();
    test_bias_relu();
    test_precision();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_cadence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv1_filter_q16.md
Name: conv1_filter_q16

Overview:
Single 3x3 convolution filter (one output channel) for the first conv layer. It computes the dot product of a 9-element input window with 9 weights, adds a bias, and applies ReLU and saturation. The datapath is fully pipelined, with a fixed latency of 3 cycles. conv1_calc instantiates it 9x32 times in round-robin banks and samples filter_out 9 cycles after issuing a window, so the latency must never exceed 8.

Parameters:
DATA_W, 32, width of every data/weight/bias/output word
FRAC_W, 16, fractional bits of the signed fixed-point format (Q16.16)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-high (asserted = 1) despite the name
valid_in  input  1  window/weights/bias valid; sampled on each rising edge
data_out  input  [DATA_W-1:0] x9 (unpacked [0:8])  3x3 input window, row-major, signed Q16.16
weight  input  [DATA_W-1:0] x9 (unpacked [0:8])  3x3 kernel, index-aligned with data_out, signed Q16.16
bias  input  [DATA_W-1:0]  signed Q16.16 bias for this filter
filter_out  output  [DATA_W-1:0]  registered result, Q16.16, always >= 0

Behaviour:
- All arithmetic is two's-complement signed. No floating point.
- Stage 1 (edge N, when valid_in=1):
  - Register the 9 full-precision products p[k] = data_out[k]*weight[k], each 64-bit signed (Q32.32).
  - Register bias sign-extended and shifted left by FRAC_W into the same Q32.32 domain.
  - Set internal valid v1.
- Stage 2 (edge N+1, when v1=1):
  - Adder tree over p[0..8] plus bias, kept at full precision (at least 68 bits, no intermediate truncation).
  - Register the sum and set v2.
- Stage 3 (edge N+2, when v2=1): filter_out is loaded with the result of the following steps.
  - r = sum arithmetically shifted right by FRAC_W (floor rounding toward -inf, no round-to-nearest).
  - ReLU: r < 0 gives 0.
  - Saturate: r > 0x7FFFFFFF gives 0x7FFFFFFF.
  - Otherwise filter_out = r[31:0].
- Latency: inputs sampled at edge N appear on filter_out after edge N+2 (3 register stages). They are stable well before conv1_calc samples at N+9.
- Throughput: one window per cycle. valid_in may stay high on consecutive cycles, including with unchanged inputs; identical inputs produce identical outputs.
- valid_in=0 at an edge:
  - Stage-1 registers and v1 are not updated; v1 goes low.
  - Bubbles propagate.
  - filter_out holds its last value whenever v2=0 at an edge.
- No output valid is produced; the parent tracks timing with its own delay line.
- Inputs are captured only at stage 1. Changes to data_out/weight/bias after capture do not affect in-flight results.
- Reset (rst_n=1, asynchronous, any time including mid-pipeline):
  - filter_out = 0, all stage valids = 0, and product/sum registers cleared to 0.
  - In-flight results are discarded.
  - The first result after reset release follows the normal 3-cycle latency.
- No X propagation: every register has a reset value.
- Implementation size target: about 120-250 lines. Nine multipliers and a 10-input adder tree with an optional register split are acceptable, as long as the total latency remains exactly 3.

Test Plan:
1. Reset:
   - Assert rst_n=1 for 2 cycles with random inputs -> filter_out=0x00000000.
   - Release and hold valid_in=0 -> filter_out stays 0.
2. Basic dot product: data_out all 0x00010000 (1.0), weight all 0x00010000, bias 0, valid_in pulse at edge N -> filter_out=0x00090000 after edge N+2 and held afterwards.
3. Bias and ReLU:
   - weight all 0, bias 0x00028000 -> 0x00028000.
   - weight all 0xFFFF0000 (-1.0), data 1.0, bias 0x00010000 -> sum -8.0 -> filter_out=0x00000000.
4. Precision/floor:
   - data all 0x00000001, weight all 0x00008000, bias 0 -> sum 9*2^-17 -> filter_out=0x00000004.
   - data 0x00000001, weight 0xFFFF8000, bias 0 -> negative -> 0.
5. Saturation and pipelining:
   - data and weight all 0x7FFFFFFF, bias 0x7FFFFFFF -> 0x7FFFFFFF.
   - Back-to-back valids with windows A (-> 9.0), B (-> 0), C (-> 2.5) on consecutive edges -> outputs 0x00090000, 0x00000000, 0x00028000 on consecutive cycles.
6. Reset mid-operation and 9-cycle cadence:
   - Assert reset 1 cycle after a valid window -> output 0 and no stale result appears later.
   - Issue windows every 9 cycles as conv1_calc does -> each result is stable from N+2 through N+9.
